// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: one pipeline stage with valid/ready handshakes on both sides.
// A two-entry skid buffer (main + skid) lets the stage accept one more entry
// while downstream stalls, so in_ready is a plain register output and no
// in-flight entry is ever dropped. A synchronous flush discards everything
// held plus any same-cycle incoming entry.
//
// Optional feature macro: PIPE_STATS_EN (adds stall_cnt / flush_cnt counters
// and the CNT_W parameter).
//
// Ports:
//   clk        in   rising-edge clock
//   clr        in   asynchronous active-high reset
//   flush      in   synchronous bubble request (highest priority)
//   in_valid   in   upstream entry valid
//   in_ready   out  stage can accept an entry this cycle (registered)
//   in_ctrl    in   upstream control vector [CTRL_W]
//   in_data    in   upstream data payload [DATA_W]
//   out_valid  out  main entry valid (registered)
//   out_ready  in   downstream accepts the entry this cycle
//   out_ctrl   out  main control, forced to 0 while out_valid=0
//   out_data   out  main data, holds last value while invalid (registered)
//   stall_cnt  out  saturating stall-cycle count   (PIPE_STATS_EN only)
//   flush_cnt  out  saturating effective-flush count (PIPE_STATS_EN only)

module pipe_skid_reg #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 111
`ifdef PIPE_STATS_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [DATA_W-1:0]   r_skid_data;

  logic                w_accept;
  logic                w_consume;
  logic                w_load_main_in;
  logic                w_load_main_skid;
  logic                w_load_skid;

  assign w_accept  = in_valid & r_in_ready;
  assign w_consume = r_out_valid & out_ready;

  // Next-state and register-load decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_consume) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_consume) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_consume) begin
          w_state_nxt      = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
    // Flush overrides everything; main data is left untouched so out_data holds.
    if (flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  // State plus handshake flags, registered from the next state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  // Main and skid payload registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_load_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main_data;
  // Control is bubbled to zero whenever the entry is not valid.
  assign out_ctrl  = r_main_ctrl & {CTRL_W{r_out_valid}};

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_evt;
  logic             w_flush_evt;

  assign w_stall_evt = r_out_valid & ~out_ready;
  // A flush only counts when it actually discards something.
  assign w_flush_evt = flush & ((r_state != ST_EMPTY) | in_valid);

  // Saturating statistics counters; flush does not clear them.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_evt && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg. Stimulus is driven 1 time unit after
// each rising edge; a monitor on the falling edge compares the DUT against a
// two-deep FIFO reference model held in a queue and advances that model to
// predict the next rising edge.

module tb_pipe_skid_reg;

  localparam int unsigned CW  = 8;
  localparam int unsigned DW  = 32;
`ifdef PIPE_STATS_EN
  localparam int unsigned SW  = 2;
  localparam int          SAT = 3;
`endif

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          clr;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
`ifdef PIPE_STATS_EN
  logic [SW-1:0] stall_cnt;
  logic [SW-1:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ent_t          q[$];
  ent_t          e;
  logic [DW-1:0] last_data = '0;
  bit            mon_en = 1'b0;
  int            seen_1f = 0;
`ifdef PIPE_STATS_EN
  int exp_stall = 0;
  int exp_flush = 0;
`endif

  pipe_skid_reg #(
    .CTRL_W(CW),
    .DATA_W(DW)
`ifdef PIPE_STATS_EN
    ,
    .CNT_W(SW)
`endif
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data)
`ifdef PIPE_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic r, input logic f);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  // Monitor + reference model: check what the DUT presents now, then predict the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      bit acc;
      bit con;
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() == 0) begin
        chk("idle_ctrl", 64'(out_ctrl), 64'(0));
        chk("idle_data", 64'(out_data), 64'(last_data));
      end
`ifdef PIPE_STATS_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      chk("flush_cnt", 64'(flush_cnt), 64'(exp_flush));
      if (q.size() > 0 && !out_ready && exp_stall < SAT) exp_stall++;
      if (flush && (q.size() > 0 || in_valid) && exp_flush < SAT) exp_flush++;
`endif
      acc = in_valid && (q.size() < 2);
      con = (q.size() > 0) && out_ready;
      if (con) begin
        e = q.pop_front();
        chk("out_ctrl", 64'(out_ctrl), 64'(e.c));
        chk("out_data", 64'(out_data), 64'(e.d));
        if (out_data == DW'(32'h1F)) seen_1f++;
      end
      if (flush) begin
        q.delete();
      end else if (acc) begin
        q.push_back('{c: in_ctrl, d: in_data});
      end
      if (q.size() > 0) last_data = q[0].d;
    end
  end

  initial begin
    clr = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_ctrl", 64'(out_ctrl), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    #1;
    clr = 1'b0;
    mon_en = 1'b1;

    // Streaming at full rate.
    for (int i = 1; i <= 5; i++) drive(1'b1, 8'hA5, DW'(i), 1'b1, 1'b0);
    drive(1'b0, 8'h00, '0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, '0, 1'b1, 1'b0);

    // Stall into skid, ignored offer, then release.
    drive(1'b1, 8'hA5, DW'(32'h0F), 1'b0, 1'b0);
    drive(1'b1, 8'hA5, DW'(32'h0C), 1'b0, 1'b0);
    drive(1'b1, 8'hA5, DW'(32'h0D), 1'b0, 1'b0);
    drive(1'b1, 8'hA5, DW'(32'h0D), 1'b1, 1'b0);
    drive(1'b1, 8'hA5, DW'(32'h0D), 1'b1, 1'b0);
    drive(1'b0, 8'h00, '0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, '0, 1'b1, 1'b0);

    // Flush while full with a same-cycle incoming entry.
    drive(1'b1, 8'h5A, DW'(32'h1D), 1'b0, 1'b0);
    drive(1'b1, 8'h5A, DW'(32'h1E), 1'b0, 1'b0);
    drive(1'b1, 8'h5A, DW'(32'h1F), 1'b0, 1'b1);
    drive(1'b0, 8'h00, '0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, '0, 1'b1, 1'b0);

    // Drain: one entry then idle, data must be retained.
    drive(1'b1, 8'h33, DW'(32'h77), 1'b1, 1'b0);
    drive(1'b0, 8'h00, '0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, '0, 1'b1, 1'b0);

    // Long stall then flushes (exercises counter saturation when enabled).
    drive(1'b1, 8'h11, DW'(32'h21), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, '0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, '0, 1'b0, 1'b1);
    drive(1'b1, 8'h12, DW'(32'h22), 1'b0, 1'b0);
    drive(1'b0, 8'h00, '0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, '0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, '0, 1'b1, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 60, CW'($urandom), DW'($urandom),
            $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 5);
    end

    // Asynchronous clear mid-cycle with random inputs.
    drive(1'b1, CW'($urandom), DW'($urandom), 1'b0, 1'b0);
    drive(1'b1, CW'($urandom), DW'($urandom), 1'b0, 1'b0);
    mon_en = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    chk("clr_in_ready", 64'(in_ready), 64'(1));
    chk("clr_out_valid", 64'(out_valid), 64'(0));
    chk("clr_out_ctrl", 64'(out_ctrl), 64'(0));
    chk("clr_out_data", 64'(out_data), 64'(0));
`ifdef PIPE_STATS_EN
    chk("clr_stall_cnt", 64'(stall_cnt), 64'(0));
    chk("clr_flush_cnt", 64'(flush_cnt), 64'(0));
    exp_stall = 0;
    exp_flush = 0;
`endif
    clr = 1'b0;
    q.delete();
    last_data = '0;
    mon_en = 1'b1;

    for (int i = 0; i < 100; i++) begin
      drive($urandom_range(0, 99) < 70, CW'($urandom), DW'($urandom),
            $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3);
    end

    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, '0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("model_drained", 64'(q.size()), 64'(0));
    chk("flushed_1f_never_out", 64'(seen_1f), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
